alu_cmd_sequencer: RTL and testbench

Command-side companion to the datapath ALU. It accepts ALU commands (op, 8-bit num1, 32-bit num2) over a valid/ready request channel and registers them onto the ALU operand ports. It captures the ALU's combinational result one cycle later and returns it over a valid/ready response channel. It sits between the lab test/control logic (or board I/O wrapper) and the ALU, giving the ALU a clean, handshaked, registered front and back end.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 29 ++
 rtl/alu_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, reserved-op helper and the
// command sequencer state type, imported by the ALU and sequencer.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_RSV3 = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_RSV5 = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } seq_state_e;

  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op == OP_RSV3) || (op == OP_RSV5);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU. num1 is zero-extended to 32 bits.
// Ports: op/num1/num2 operands in, ans result out (0 for reserved ops).
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [7:0]  num1,
  input  logic [31:0] num2,
  output logic [31:0] ans
);

  logic [31:0] a;

  assign a = {24'b0, num1};

  always_comb begin
    ans = '0;
    unique case (op)
      OP_AND:  ans = a & num2;
      OP_OR:   ans = a | num2;
      OP_ADD:  ans = a + num2;
      OP_NOT:  ans = ~a;
      OP_SUB:  ans = a - num2;
      OP_SLT:  ans = {31'b0, a < num2};
      default: ans = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registers handshaked ALU commands onto the ALU ports and returns the
// captured result over a valid/ready response channel.
// Ports: clk/rst (sync, active-high); cmd_* request channel; alu_*
// operand/result ports; rsp_* response channel; done_cnt (wrapping).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_num1,
  input  logic [31:0]      cmd_num2,
  output logic [2:0]       alu_op,
  output logic [7:0]       alu_num1,
  output logic [31:0]      alu_num2,
  input  logic [31:0]      alu_ans,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       n1_q, n1_d;
  logic [31:0]      n2_q, n2_d;
  logic             rv_q, rv_d;
  logic [31:0]      rd_q, rd_d;
  logic [2:0]       rop_q, rop_d;
  logic             rerr_q, rerr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ready depends on state only; rst masks it so nothing is
  // accepted on a reset edge.
  assign cmd_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rop_d   = rop_q;
    rerr_d  = rerr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          n1_d    = cmd_num1;
          n2_d    = cmd_num2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_d    = alu_ans;
        rop_d   = op_q;
        rerr_d  = is_reserved_op(op_q);
        rv_d    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rop_q   <= '0;
      rerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rop_q   <= rop_d;
      rerr_q  <= rerr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_num1  = n1_q;
  assign alu_num2  = n2_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign rsp_op    = rop_q;
  assign rsp_err   = rerr_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: sequencer plus real ALU, and a CNT_W=2 copy for
// the counter wrap.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, alu_op, rsp_op;
  logic [7:0]  cmd_num1, alu_num1;
  logic [31:0] cmd_num2, alu_num2, alu_ans, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] done_cnt;

  logic        cv2, cr2, rv2, rr2, re2;
  logic [2:0]  co2, ao2, ro2;
  logic [7:0]  c12, a12;
  logic [31:0] c22, a22, aa2, rd2;
  logic [1:0]  dc2;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_num1(cmd_num1), .cmd_num2(cmd_num2),
    .alu_op(alu_op), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_ans(alu_ans),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .done_cnt(done_cnt)
  );

  alu u_alu (
    .op(alu_op), .num1(alu_num1), .num2(alu_num2), .ans(alu_ans)
  );

  alu_cmd_sequencer #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv2), .cmd_ready(cr2),
    .cmd_op(co2), .cmd_num1(c12), .cmd_num2(c22),
    .alu_op(ao2), .alu_num1(a12), .alu_num2(a22),
    .alu_ans(aa2),
    .rsp_valid(rv2), .rsp_ready(rr2),
    .rsp_data(rd2), .rsp_op(ro2), .rsp_err(re2),
    .done_cnt(dc2)
  );

  alu u_alu2 (.op(ao2), .num1(a12), .num2(a22), .ans(aa2));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction with rsp_ready asserted as soon as rsp_valid shows.
  task automatic run_cmd(input string tag, input logic [2:0] op,
                         input logic [7:0] n1, input logic [31:0] n2,
                         input logic [31:0] exp_d, input logic exp_e,
                         input logic [15:0] exp_cnt);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_num1 = n1;
    cmd_num2 = n2;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, ".alu_n2"}, alu_num2, n2);
    chk({tag, ".rv0"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".rv1"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".data"}, rsp_data, exp_d);
    chk({tag, ".rop"}, 32'(rsp_op), 32'(op));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rvoff"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cnt"}, 32'(done_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_num1 = '0; cmd_num2 = '0;
    rsp_ready = 1'b0;
    cv2 = 1'b0; co2 = '0; c12 = '0; c22 = '0; rr2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(cmd_ready), 32'd0);
    chk("rst.rv", 32'(rsp_valid), 32'd0);
    chk("rst.data", rsp_data, 32'd0);
    chk("rst.cnt", 32'(done_cnt), 32'd0);
    chk("rst.alu_n2", alu_num2, 32'd0);
    rst = 1'b0;

    run_cmd("add", OP_ADD, 8'h05, 32'h10, 32'h15, 1'b0, 16'd1);
    run_cmd("sub", OP_SUB, 8'h03, 32'h05, 32'hFFFF_FFFE, 1'b0, 16'd2);
    run_cmd("slt", OP_SLT, 8'hFF, 32'h100, 32'd1, 1'b0, 16'd3);
    run_cmd("not", OP_NOT, 8'h0F, 32'h0, 32'hFFFF_FFF0, 1'b0, 16'd4);
    run_cmd("rsv3", OP_RSV3, 8'h12, 32'h34, 32'd0, 1'b1, 16'd5);
    run_cmd("rsv5", OP_RSV5, 8'h12, 32'h34, 32'd0, 1'b1, 16'd6);

    // Backpressure with a second command pending.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_AND; cmd_num1 = 8'hF0; cmd_num2 = 32'hFF;
    @(negedge clk);
    cmd_op = OP_OR; cmd_num1 = 8'h0A; cmd_num2 = 32'h100;
    @(negedge clk);
    chk("bp.rv", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_rv", 32'(rsp_valid), 32'd1);
      chk("bp.hold_d", rsp_data, 32'hF0);
      chk("bp.hold_op", 32'(rsp_op), 32'(OP_AND));
      chk("bp.hold_err", 32'(rsp_err), 32'd0);
      chk("bp.ready", 32'(cmd_ready), 32'd0);
      chk("bp.alu_op", 32'(alu_op), 32'(OP_AND));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.rvoff", 32'(rsp_valid), 32'd0);
    chk("bp.cnt", 32'(done_cnt), 32'd7);
    chk("bp.idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp2.alu_op", 32'(alu_op), 32'(OP_OR));
    @(negedge clk);
    chk("bp2.rv", 32'(rsp_valid), 32'd1);
    chk("bp2.data", rsp_data, 32'h10A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp2.cnt", 32'(done_cnt), 32'd8);

    // Reset while in ISSUE.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_ADD; cmd_num1 = 8'h77; cmd_num2 = 32'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mr.issue", alu_num2, 32'h1234);
    rst = 1'b1;
    @(negedge clk);
    chk("mr.rv", 32'(rsp_valid), 32'd0);
    chk("mr.alu_op", 32'(alu_op), 32'd0);
    chk("mr.alu_n1", 32'(alu_num1), 32'd0);
    chk("mr.alu_n2", alu_num2, 32'd0);
    chk("mr.cnt", 32'(done_cnt), 32'd0);
    chk("mr.ready_rst", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr.ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("mr.rv_after", 32'(rsp_valid), 32'd0);

    // Counter wrap on the 2-bit instance: ADD i+i each time.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("wr.ready", 32'(cr2), 32'd1);
      cv2 = 1'b1; co2 = OP_ADD; c12 = 8'(i); c22 = 32'(i);
      @(negedge clk);
      cv2 = 1'b0;
      @(negedge clk);
      chk("wr.rv", 32'(rv2), 32'd1);
      chk("wr.data", rd2, 32'(2 * i));
      rr2 = 1'b1;
      @(negedge clk);
      rr2 = 1'b0;
      chk("wr.cnt", 32'(dc2), 32'(i % 4));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
